// File: rtl/imem_dmem_arbiter.sv
// Purpose: shares one single-port unified memory between instruction fetch and data load/store.
// Latency: a request seen in IDLE at cycle N is in ACCESS at N+1; the done pulse and data follow at N+2.
// Backpressure: one access per 3 cycles. Data beats fetch unless fetch has lost FETCH_WAIT_MAX contended rounds.
// Optional build macro MISALIGN_CHECK_EN: adds o_misaligned and suppresses writes/capture on addr[1:0] != 0.
module imem_dmem_arbiter #(
  parameter int FETCH_WAIT_MAX = 2,
  parameter int ADDR_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_fetchReq,
  input  logic [ADDR_W-1:0] i_fetchAddr,
  output logic              o_fetchDone,
  output logic [31:0]       o_instr,
  input  logic              i_dataReq,
  input  logic              i_dataWe,
  input  logic [ADDR_W-1:0] i_dataAddr,
  input  logic [31:0]       i_dataWdata,
  output logic              o_dataDone,
  output logic [31:0]       o_dataRdata,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic              o_memWe,
  output logic [31:0]       o_memWdata,
  input  logic [31:0]       i_memRdata,
`ifdef MISALIGN_CHECK_EN
  output logic              o_misaligned,
`endif
  output logic              o_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] WAIT_MAX = 4'(FETCH_WAIT_MAX);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;       // contended rounds fetch has lost in a row
  logic              win_data_q, win_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              pick_data;
  logic              in_access;

`ifdef MISALIGN_CHECK_EN
  logic              mis_q, mis_d;
`else
  logic              mis_q;
  assign mis_q = 1'b0;
`endif

  // Arbitration, latching of the winner's request, and capture of read data.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_data_d = win_data_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    pick_data  = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis_d      = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_fetchReq || i_dataReq) begin
          // Data wins unless fetch is contending and has hit its starvation limit.
          pick_data = i_dataReq && !(i_fetchReq && (cnt_q == WAIT_MAX));
          if (pick_data) begin
            addr_d  = i_dataAddr;
            we_d    = i_dataWe;
            wdata_d = i_dataWdata;
            if (i_fetchReq && (cnt_q != WAIT_MAX)) begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            addr_d  = i_fetchAddr;
            we_d    = 1'b0;
            wdata_d = '0;
            cnt_d   = '0;
          end
          win_data_d = pick_data;
`ifdef MISALIGN_CHECK_EN
          mis_d = pick_data ? (i_dataAddr[1:0] != 2'b00) : (i_fetchAddr[1:0] != 2'b00);
`endif
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Stores leave o_dataRdata untouched; misaligned reads load 0.
        if (win_data_q) begin
          if (!we_q) begin
            rdata_d = mis_q ? 32'd0 : i_memRdata;
          end
        end else begin
          instr_d = mis_q ? 32'd0 : i_memRdata;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset returns to IDLE immediately so a pending write is dropped.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      win_data_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      instr_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_data_q <= win_data_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef MISALIGN_CHECK_EN
  // Misalignment flag of the current transaction.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign o_misaligned = (state_q == S_DONE) && mis_q;
`endif

  // Memory port is only driven during ACCESS; zero everywhere else.
  assign in_access   = (state_q == S_ACCESS);
  assign o_memAddr   = in_access ? addr_q : '0;
  assign o_memWe     = in_access && we_q && !mis_q;
  assign o_memWdata  = in_access ? wdata_q : '0;

  assign o_fetchDone = (state_q == S_DONE) && !win_data_q;
  assign o_dataDone  = (state_q == S_DONE) && win_data_q;
  assign o_instr     = instr_q;
  assign o_dataRdata = rdata_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a small behavioural memory.
// Inputs change and outputs are sampled on the falling edge.
// Grant order, latency and write counts are tracked by the step task.
module tb_imem_dmem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic        i_fetchReq;
  logic [31:0] i_fetchAddr;
  logic        o_fetchDone;
  logic [31:0] o_instr;
  logic        i_dataReq;
  logic        i_dataWe;
  logic [31:0] i_dataAddr;
  logic [31:0] i_dataWdata;
  logic        o_dataDone;
  logic [31:0] o_dataRdata;
  logic [31:0] o_memAddr;
  logic        o_memWe;
  logic [31:0] o_memWdata;
  logic [31:0] i_memRdata;
  logic        o_busy;
`ifdef MISALIGN_CHECK_EN
  logic        o_misaligned;
`endif

  always #5 i_clk = ~i_clk;

  imem_dmem_arbiter #(.FETCH_WAIT_MAX(2), .ADDR_W(32)) dut (
    .i_clk       (i_clk),
    .i_arst_n    (i_arst_n),
    .i_fetchReq  (i_fetchReq),
    .i_fetchAddr (i_fetchAddr),
    .o_fetchDone (o_fetchDone),
    .o_instr     (o_instr),
    .i_dataReq   (i_dataReq),
    .i_dataWe    (i_dataWe),
    .i_dataAddr  (i_dataAddr),
    .i_dataWdata (i_dataWdata),
    .o_dataDone  (o_dataDone),
    .o_dataRdata (o_dataRdata),
    .o_memAddr   (o_memAddr),
    .o_memWe     (o_memWe),
    .o_memWdata  (o_memWdata),
    .i_memRdata  (i_memRdata),
`ifdef MISALIGN_CHECK_EN
    .o_misaligned(o_misaligned),
`endif
    .o_busy      (o_busy)
  );

  // Word-indexed memory: combinational read, write on rising edge.
  logic [31:0] mem [0:63];
  assign i_memRdata = mem[o_memAddr[7:2]];
  always @(posedge i_clk) begin
    if (o_memWe) mem[o_memAddr[7:2]] <= o_memWdata;
  end

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int gn = 0;
  logic [7:0] glog;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // One falling edge; record writes and done pulses (1 = data grant, 0 = fetch grant).
  task automatic step();
    @(negedge i_clk);
    if (o_memWe === 1'b1) we_cnt++;
    if (o_dataDone === 1'b1 || o_fetchDone === 1'b1) begin
      if (gn < 8) glog[gn] = o_dataDone;
      gn++;
    end
  endtask

  // Number of falling edges until the selected done pulse; 0 if it never came.
  task automatic wait_done(input bit is_data, output int n);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (is_data ? o_dataDone : o_fetchDone) begin
        n = k;
        break;
      end
    end
  endtask

  int lat;
  int a0, a1;
  int gsave;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h00500093;   // 0x10
    mem[8]  = 32'h0BADF00D;   // 0x20
    mem[12] = 32'h12345678;   // 0x30
    i_arst_n = 1'b0;
    i_fetchReq = 1'b0; i_fetchAddr = '0;
    i_dataReq = 1'b0; i_dataWe = 1'b0; i_dataAddr = '0; i_dataWdata = '0;
    glog = '0;

    // Reset state
    step(); step();
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_we",    {31'd0, o_memWe}, 32'd0);
    check("rst_addr",  o_memAddr, 32'd0);
    check("rst_instr", o_instr, 32'd0);
    check("rst_done",  {30'd0, o_fetchDone, o_dataDone}, 32'd0);
    i_arst_n = 1'b1;
    step();

    // Fetch only from 0x10
    we_cnt = 0;
    i_fetchReq = 1'b1; i_fetchAddr = 32'h10;
    wait_done(1'b0, lat);
    i_fetchReq = 1'b0;
    check("fetch_lat",   lat, 32'd2);
    check("fetch_instr", o_instr, 32'h00500093);
    step();
    check("fetch_no_we", we_cnt, 32'd0);
    check("fetch_idle",  {31'd0, o_busy}, 32'd0);

    // Store 0xDEADBEEF to 0x24
    we_cnt = 0;
    i_dataReq = 1'b1; i_dataWe = 1'b1; i_dataAddr = 32'h24; i_dataWdata = 32'hDEADBEEF;
    step();
    check("st_addr", o_memAddr, 32'h24);
    check("st_we",   {31'd0, o_memWe}, 32'd1);
    step();
    check("st_done", {31'd0, o_dataDone}, 32'd1);
    i_dataReq = 1'b0; i_dataWe = 1'b0;
    step();
    check("st_we_cnt", we_cnt, 32'd1);
    check("st_mem",    mem[9], 32'hDEADBEEF);
    check("st_rdata_hold", o_dataRdata, 32'd0);

    // Load back from 0x24
    i_dataReq = 1'b1; i_dataWe = 1'b0; i_dataAddr = 32'h24;
    wait_done(1'b1, lat);
    i_dataReq = 1'b0;
    check("ld_lat",   lat, 32'd2);
    check("ld_rdata", o_dataRdata, 32'hDEADBEEF);
    step();

    // Contention: both requests held, expect D,D,F,D,D,F
    gn = 0; glog = '0;
    i_fetchReq = 1'b1; i_fetchAddr = 32'h10;
    i_dataReq = 1'b1; i_dataWe = 1'b0; i_dataAddr = 32'h30;
    for (int k = 0; k < 40 && gn < 6; k++) step();
    i_fetchReq = 1'b0; i_dataReq = 1'b0;
    check("cont_count", gn, 32'd6);
    check("cont_order", {26'd0, glog[5:0]}, 32'h1B);
    check("cont_rdata", o_dataRdata, 32'h12345678);
    step();

    // Back-to-back fetch with request held through DONE
    a0 = -1; a1 = -1;
    i_fetchReq = 1'b1; i_fetchAddr = 32'h10;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (o_busy && !o_fetchDone && !o_dataDone) begin
        if (a0 < 0) a0 = k;
        else if (a1 < 0) a1 = k;
      end
      if (a1 >= 0 && o_fetchDone) begin
        i_fetchReq = 1'b0;
        break;
      end
    end
    i_fetchReq = 1'b0;
    check("b2b_first", a0, 32'd1);
    check("b2b_gap",   a1 - a0, 32'd3);
    step();

    // Reset during ACCESS of a store to 0x30
    i_dataReq = 1'b1; i_dataWe = 1'b1; i_dataAddr = 32'h30; i_dataWdata = 32'hAAAA5555;
    step();
    check("rst_mid_we_before", {31'd0, o_memWe}, 32'd1);
    gsave = gn;
    #1 i_arst_n = 1'b0;
    #1;
    check("rst_mid_we_drop", {31'd0, o_memWe}, 32'd0);
    check("rst_mid_busy",    {31'd0, o_busy}, 32'd0);
    i_dataReq = 1'b0; i_dataWe = 1'b0;
    step();
    i_arst_n = 1'b1;
    step(); step();
    check("rst_mid_mem",   mem[12], 32'h12345678);
    check("rst_mid_nodone", gn - gsave, 32'd0);
    check("rst_mid_rdata", o_dataRdata, 32'd0);
    check("rst_mid_instr", o_instr, 32'd0);

    // Store to misaligned address 0x22
    we_cnt = 0;
    i_dataReq = 1'b1; i_dataWe = 1'b1; i_dataAddr = 32'h22; i_dataWdata = 32'h00000055;
    step();
`ifdef MISALIGN_CHECK_EN
    check("mis_we", {31'd0, o_memWe}, 32'd0);
    step();
    check("mis_pulse", {30'd0, o_misaligned, o_dataDone}, 32'd3);
    i_dataReq = 1'b0; i_dataWe = 1'b0;
    step();
    check("mis_mem",   mem[8], 32'h0BADF00D);
    check("mis_clear", {31'd0, o_misaligned}, 32'd0);
`else
    check("mis_addr", o_memAddr, 32'h22);
    check("mis_we",   {31'd0, o_memWe}, 32'd1);
    step();
    check("mis_done", {31'd0, o_dataDone}, 32'd1);
    i_dataReq = 1'b0; i_dataWe = 1'b0;
    step();
    check("mis_mem", mem[8], 32'h00000055);
`endif
    check("mis_we_cnt", we_cnt, 32'd1 - (`ifdef MISALIGN_CHECK_EN 32'd1 `else 32'd0 `endif));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
